// File: rtl/clock_time_set_pkg.sv
// clock_time_set_pkg: state encodings, BCD digit limits (CLOCK_12H_EN selects 12-hour hour limits) and the MODE step helper
package clock_time_set_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'b00, ST_SET_HR = 2'b01, ST_SET_MIN = 2'b10} state_t;
  localparam int SEC_MAX_T = 5;
  localparam int SEC_MAX_O = 9;
  localparam int MIN_MAX_T = 5;
  localparam int MIN_MAX_O = 9;
`ifdef CLOCK_12H_EN
  localparam int HR_MAX_T = 1;
  localparam int HR_MAX_O = 2;
  localparam int HR_MIN_O = 1;
  localparam int HR_RST_T = 1;
  localparam int HR_RST_O = 2;
`else
  localparam int HR_MAX_T = 2;
  localparam int HR_MAX_O = 3;
  localparam int HR_MIN_O = 0;
  localparam int HR_RST_T = 0;
  localparam int HR_RST_O = 0;
`endif
  function automatic state_t step_mode(state_t s);
    return s == ST_RUN ? ST_SET_HR : s == ST_SET_HR ? ST_SET_MIN : ST_RUN;
  endfunction
endpackage

// File: rtl/clock_time_set_if.sv
// clock_time_set_if: tick/button inputs and BCD time/state outputs; master drives inputs, slave is the clock core; o_pm only with CLOCK_12H_EN
interface clock_time_set_if;
  logic i_sec_tick;
  logic i_mode_btn;
  logic i_inc_btn;
  logic [1:0] o_hr_t;
  logic [3:0] o_hr_o;
  logic [2:0] o_min_t;
  logic [3:0] o_min_o;
  logic [2:0] o_sec_t;
  logic [3:0] o_sec_o;
  logic [1:0] o_state;
`ifdef CLOCK_12H_EN
  logic o_pm;
  modport master(output i_sec_tick, i_mode_btn, i_inc_btn,
                 input o_hr_t, o_hr_o, o_min_t, o_min_o, o_sec_t, o_sec_o, o_state, o_pm);
  modport slave(input i_sec_tick, i_mode_btn, i_inc_btn,
                output o_hr_t, o_hr_o, o_min_t, o_min_o, o_sec_t, o_sec_o, o_state, o_pm);
`else
  modport master(output i_sec_tick, i_mode_btn, i_inc_btn,
                 input o_hr_t, o_hr_o, o_min_t, o_min_o, o_sec_t, o_sec_o, o_state);
  modport slave(input i_sec_tick, i_mode_btn, i_inc_btn,
                output o_hr_t, o_hr_o, o_min_t, o_min_o, o_sec_t, o_sec_o, o_state);
`endif
endinterface

// File: rtl/clock_time_set_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter MIN..MAX with inc/clear (clear loads RST value), carry high when inc wraps MAX->MIN; ports clk, rst, inc, clear, t, o, carry
module bcd_mod_counter #(
  parameter int T_W = 3,
  parameter int MAX_T = 5,
  parameter int MAX_O = 9,
  parameter int MIN_T = 0,
  parameter int MIN_O = 0,
  parameter int RST_T = 0,
  parameter int RST_O = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           clear,
  output logic [T_W-1:0] t,
  output logic [3:0]     o,
  output logic           carry
);
  logic at_max;
  assign at_max = t == T_W'(MAX_T) && o == 4'(MAX_O);
  assign carry = inc && at_max;
  always_ff @(posedge clk)
    if (rst || clear) begin
      t <= T_W'(RST_T);
      o <= 4'(RST_O);
    end else if (inc) begin
      t <= at_max ? T_W'(MIN_T) : o == 4'd9 ? t + T_W'(1) : t;
      o <= at_max ? 4'(MIN_O) : o == 4'd9 ? 4'd0 : o + 4'd1;
    end
endmodule

// File: rtl/clock_time_set.sv
// clock_time_set: BCD HH:MM:SS clock with MODE/INC time setting and SET-state timeout; ports i_clk, i_rst, bus (clock_time_set_if.slave); CLOCK_12H_EN selects 12-hour with o_pm
module clock_time_set
  import clock_time_set_pkg::*;
#(
  parameter int SET_TIMEOUT = 30
) (
  input logic             i_clk,
  input logic             i_rst,
  clock_time_set_if.slave bus
);
  state_t state, nxt;
  logic mode_prev, inc_prev, mode_ev, inc_ev, set_st, timeout;
  logic sec_inc, sec_clr, min_inc, hr_inc, sec_carry, min_carry, hr_carry_unused;
  logic [5:0] tcnt;
  logic [2:0] sec_t, min_t;
  logic [3:0] sec_o, min_o, hr_o;
  logic [1:0] hr_t;
  assign mode_ev = bus.i_mode_btn && !mode_prev;
  assign inc_ev = bus.i_inc_btn && !inc_prev && !mode_ev;
  assign set_st = state == ST_SET_HR || state == ST_SET_MIN;
  // A press in the same cycle restarts the idle count, so it also suppresses the timeout
  assign timeout = SET_TIMEOUT != 0 && set_st && bus.i_sec_tick && !mode_ev && !inc_ev &&
                   tcnt == 6'(SET_TIMEOUT - 1);
  always_ff @(posedge i_clk)
    if (i_rst) state <= ST_RUN;
    else state <= nxt;
  always_comb nxt = mode_ev ? step_mode(state) : (set_st && !timeout) ? state : ST_RUN;
  assign sec_inc = state == ST_RUN && bus.i_sec_tick;
  assign sec_clr = (state == ST_SET_MIN && mode_ev) || timeout;
  assign min_inc = state == ST_RUN ? sec_carry : state == ST_SET_MIN && inc_ev;
  assign hr_inc = state == ST_RUN ? min_carry : state == ST_SET_HR && inc_ev;
  // prev regs start high so a button held through reset produces no event
  always_ff @(posedge i_clk)
    if (i_rst) begin
      mode_prev <= 1'b1;
      inc_prev <= 1'b1;
      tcnt <= '0;
    end else begin
      mode_prev <= bus.i_mode_btn;
      inc_prev <= bus.i_inc_btn;
      tcnt <= (nxt != state || mode_ev || inc_ev || !set_st) ? '0 : tcnt + 6'(bus.i_sec_tick);
    end
  bcd_mod_counter #(.T_W(3), .MAX_T(SEC_MAX_T), .MAX_O(SEC_MAX_O)) u_sec (
    .clk(i_clk), .rst(i_rst), .inc(sec_inc), .clear(sec_clr), .t(sec_t), .o(sec_o), .carry(sec_carry)
  );
  bcd_mod_counter #(.T_W(3), .MAX_T(MIN_MAX_T), .MAX_O(MIN_MAX_O)) u_min (
    .clk(i_clk), .rst(i_rst), .inc(min_inc), .clear(1'b0), .t(min_t), .o(min_o), .carry(min_carry)
  );
  bcd_mod_counter #(
    .T_W(2), .MAX_T(HR_MAX_T), .MAX_O(HR_MAX_O), .MIN_T(0), .MIN_O(HR_MIN_O),
    .RST_T(HR_RST_T), .RST_O(HR_RST_O)
  ) u_hr (
    .clk(i_clk), .rst(i_rst), .inc(hr_inc), .clear(1'b0), .t(hr_t), .o(hr_o), .carry(hr_carry_unused)
  );
`ifdef CLOCK_12H_EN
  logic pm;
  // AM/PM flips on the 11->12 hour step, both when running and when setting
  always_ff @(posedge i_clk)
    if (i_rst) pm <= 1'b0;
    else if (hr_inc && hr_t == 2'd1 && hr_o == 4'd1) pm <= !pm;
  assign bus.o_pm = pm;
`endif
  assign bus.o_hr_t = hr_t;
  assign bus.o_hr_o = hr_o;
  assign bus.o_min_t = min_t;
  assign bus.o_min_o = min_o;
  assign bus.o_sec_t = sec_t;
  assign bus.o_sec_o = sec_o;
  assign bus.o_state = state;
endmodule

// File: tb/tb_clock_time_set.sv
// tb_clock_time_set: scoreboard bench comparing clock_time_set every cycle against a seconds-of-day reference model
module tb_clock_time_set;
  localparam int TO = 3;
`ifdef CLOCK_12H_EN
  localparam bit H12 = 1'b1;
`else
  localparam bit H12 = 1'b0;
`endif
  typedef struct packed {
    logic [1:0] hr_t;
    logic [3:0] hr_o;
    logic [2:0] min_t;
    logic [3:0] min_o;
    logic [2:0] sec_t;
    logic [3:0] sec_o;
    logic [1:0] st;
    logic       pm;
  } snap_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dpm;
  int checks = 0;
  int errors = 0;
  snap_t exp_q[$];
  string tag_q[$];
  string phase = "reset";
  int hr24, mn, sc, st, cnt;
  bit mprev, iprev;
  clock_time_set_if bus();
  clock_time_set #(.SET_TIMEOUT(TO)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
`ifdef CLOCK_12H_EN
  assign dpm = bus.o_pm;
`else
  assign dpm = 1'b0;
`endif
  always #5 clk = ~clk;
  function automatic snap_t show();
    int hd;
    snap_t s;
    hd = H12 ? (hr24 % 12 == 0 ? 12 : hr24 % 12) : hr24;
    s.hr_t = 2'(hd / 10);
    s.hr_o = 4'(hd % 10);
    s.min_t = 3'(mn / 10);
    s.min_o = 4'(mn % 10);
    s.sec_t = 3'(sc / 10);
    s.sec_o = 4'(sc % 10);
    s.st = 2'(st);
    s.pm = H12 && hr24 >= 12;
    return s;
  endfunction
  task automatic step(input bit r, input bit t, input bit m, input bit i);
    bit me, ie, to;
    int nst, tod;
    if (r) begin
      hr24 = 0; mn = 0; sc = 0; st = 0; cnt = 0; mprev = 1'b1; iprev = 1'b1;
      return;
    end
    me = m && !mprev;
    ie = i && !iprev && !me;
    mprev = m;
    iprev = i;
    to = TO != 0 && st != 0 && t && !me && !ie && cnt + 1 == TO;
    nst = st;
    if (st == 0 && t) begin
      tod = (hr24 * 3600 + mn * 60 + sc + 1) % 86400;
      hr24 = tod / 3600; mn = (tod / 60) % 60; sc = tod % 60;
    end
    if (st == 1 && ie) hr24 = (hr24 + 1) % 24;
    if (st == 2 && ie) mn = (mn + 1) % 60;
    if (me) begin
      if (st == 2) sc = 0;
      nst = (st + 1) % 3;
    end else if (to) begin
      sc = 0;
      nst = 0;
    end
    cnt = (nst != st || me || ie || st == 0) ? 0 : cnt + int'(t);
    st = nst;
  endtask
  task automatic cyc(input bit r, input bit t, input bit m, input bit i);
    @(negedge clk);
    rst = r;
    bus.i_sec_tick = t;
    bus.i_mode_btn = m;
    bus.i_inc_btn = i;
    step(r, t, m, i);
    exp_q.push_back(show());
    tag_q.push_back(phase);
  endtask
  task automatic tick();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic press_mode(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic press_inc(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic set_time(input int h, input int m);
    press_mode(1);
    while (hr24 != h) press_inc(2);
    press_mode(1);
    while (mn != m) press_inc(1);
    press_mode(1);
  endtask
  initial forever begin
    snap_t got, e;
    string tg;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tg = tag_q.pop_front();
      got = {bus.o_hr_t, bus.o_hr_o, bus.o_min_t, bus.o_min_o, bus.o_sec_t, bus.o_sec_o, bus.o_state, dpm};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %0d%0d:%0d%0d:%0d%0d st=%0d pm=%0d, required %0d%0d:%0d%0d:%0d%0d st=%0d pm=%0d",
                 tg, got.hr_t, got.hr_o, got.min_t, got.min_o, got.sec_t, got.sec_o, got.st, got.pm,
                 e.hr_t, e.hr_o, e.min_t, e.min_o, e.sec_t, e.sec_o, e.st, e.pm);
      end
    end
  end
  initial begin
    bit t, m, i;
    bus.i_sec_tick = 1'b0;
    bus.i_mode_btn = 1'b0;
    bus.i_inc_btn = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    phase = "run3661";
    repeat (3661) tick();
    phase = "day_wrap";
    set_time(23, 59);
    repeat (60) tick();
    phase = "mode_hold";
    press_mode(50);
    phase = "hr_inc25";
    repeat (25) press_inc(3);
    phase = "min_wrap";
    press_mode(1);
    while (mn != 59) press_inc(1);
    press_inc(1);
    phase = "exit_with_tick";
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    phase = "mode_inc_same";
    repeat (7) tick();
    press_mode(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press_mode(1);
    phase = "timeout";
    repeat (5) tick();
    press_mode(1);
    repeat (3) tick();
    phase = "timeout_restart";
    repeat (5) tick();
    press_mode(1);
    repeat (2) tick();
    press_inc(1);
    repeat (2) tick();
    tick();
    phase = "noon";
    set_time(11, 59);
    repeat (60) tick();
    phase = "rst_edit";
    press_mode(1);
    press_mode(1);
    press_inc(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    press_mode(1);
    press_mode(2);
    press_mode(1);
    phase = "random";
    t = 1'b0; m = 1'b0; i = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      t = !t && $urandom_range(3) == 0;
      if ($urandom_range(5) == 0) m = !m;
      if ($urandom_range(4) == 0) i = !i;
      cyc($urandom_range(999) == 0, t, m, i);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
